// File: rtl/systolic_input_loader.sv
// systolic_input_loader: buffers one A/B operand pair row-by-row,
// then streams A columns and B rows into a systolic_array.
module systolic_input_loader #(
  parameter int DATAWIDTH    = 16,
  parameter int N_SIZE       = 3,
  parameter int DRAIN_CYCLES = 3 * N_SIZE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_SIZE*DATAWIDTH-1:0]   in_a_row,
  input  logic [N_SIZE*DATAWIDTH-1:0]   in_b_row,
  output logic                          valid_out,
  output logic [N_SIZE*DATAWIDTH-1:0]   matrix_a_out,
  output logic [N_SIZE*DATAWIDTH-1:0]   matrix_b_out,
  output logic [15:0]                   matrix_count
);

  localparam int IW  = $clog2(N_SIZE);
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int RW  = N_SIZE * DATAWIDTH;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0]  r;
  logic [IW-1:0]  k;
  logic [DCW-1:0] d;

  logic [RW-1:0] a_buf [N_SIZE];
  logic [RW-1:0] b_buf [N_SIZE];
  logic [RW-1:0] a_col;

  logic accept;
  logic last_beat;
  logic last_col;
  logic last_drain;

  assign in_ready   = (state == LOAD);
  assign accept     = in_ready && in_valid;
  assign last_beat  = accept && (r == IW'(N_SIZE - 1));
  assign last_col   = (state == STREAM) && (k == IW'(N_SIZE - 1));
  assign last_drain = (state == DRAIN) && (d == DCW'(DRAIN_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   state_nxt = LOAD;
      LOAD:   if (last_beat)  state_nxt = STREAM;
      STREAM: if (last_col)   state_nxt = DRAIN;
      DRAIN:  if (last_drain) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand buffers; contents are don't-care until a full load lands
  always_ff @(posedge clk) begin
    if (accept) begin
      a_buf[r] <= in_a_row;
      b_buf[r] <= in_b_row;
    end
  end

  // Gather column k of A: element i comes from row i
  always_comb begin
    a_col = '0;
    for (int i = 0; i < N_SIZE; i++) begin
      a_col[i*DATAWIDTH +: DATAWIDTH] =
        a_buf[i][int'(k)*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Row, column and drain counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      k <= '0;
      d <= '0;
    end else begin
      if (accept) r <= last_beat ? '0 : r + 1'b1;
      if (state == STREAM) k <= last_col ? '0 : k + 1'b1;
      else                 k <= '0;
      if (state == DRAIN) d <= d + 1'b1;
      else                d <= '0;
    end
  end

  // Registered burst outputs and completed-burst counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out    <= 1'b0;
      matrix_a_out <= '0;
      matrix_b_out <= '0;
      matrix_count <= '0;
    end else begin
      if (state == STREAM) begin
        valid_out    <= 1'b1;
        matrix_a_out <= a_col;
        matrix_b_out <= b_buf[k];
      end else if (state == DRAIN) begin
        valid_out    <= 1'b0;
        matrix_a_out <= '0;
        matrix_b_out <= '0;
      end
      if (last_col) matrix_count <= matrix_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_systolic_input_loader.sv
// tb_systolic_input_loader: directed vectors for the operand loader,
// plus busy, reset-abort and back-to-back sequences.
module tb_systolic_input_loader;

  localparam int DW = 16;
  localparam int N  = 3;
  localparam int DC = 9;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [47:0]   in_a_row = '0;
  logic [47:0]   in_b_row = '0;
  logic          valid_out;
  logic [47:0]   matrix_a_out;
  logic [47:0]   matrix_b_out;
  logic [15:0]   matrix_count;

  systolic_input_loader #(
    .DATAWIDTH(DW),
    .N_SIZE(N),
    .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a_row(in_a_row),
    .in_b_row(in_b_row),
    .valid_out(valid_out),
    .matrix_a_out(matrix_a_out),
    .matrix_b_out(matrix_b_out),
    .matrix_count(matrix_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][47:0] a_in;
    logic [2:0][47:0] b_in;
    logic [2:0][47:0] a_exp;
    logic [2:0][47:0] b_exp;
    logic [3:0]       gap;
    logic             hold;
  } vec_t;

  vec_t tbl [4];
  int   n_run = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0][47:0] m3(
    input logic [15:0] a, b, c, d, e, f, g, h, i);
    m3 = {{i, h, g}, {f, e, d}, {c, b, a}};
  endfunction

  function automatic logic [47:0] rnd48();
    rnd48 = 48'({$urandom(), $urandom()});
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic load_beats(input vec_t v);
    wait_ready();
    for (int r = 0; r < N; r++) begin
      chk("ready_beat", 64'(in_ready), 64'd1);
      in_valid = 1;
      in_a_row = v.a_in[r];
      in_b_row = v.b_in[r];
      @(posedge clk); #1;
      in_valid = 0;
      if (r < N - 1) begin
        for (int g = 0; g < int'(v.gap); g++) begin
          in_a_row = rnd48();
          in_b_row = rnd48();
          @(posedge clk); #1;
          chk("no_valid_gap", 64'(valid_out), 64'd0);
        end
      end
    end
  endtask

  task automatic check_burst(input vec_t v);
    int n;
    in_valid = v.hold;
    chk("valid_at_E", 64'(valid_out), 64'd0);
    for (int c = 0; c < N; c++) begin
      in_a_row = rnd48();
      in_b_row = rnd48();
      @(posedge clk); #1;
      chk("burst_valid", 64'(valid_out), 64'd1);
      chk("burst_a", 64'(matrix_a_out), 64'(v.a_exp[c]));
      chk("burst_b", 64'(matrix_b_out), 64'(v.b_exp[c]));
      chk("busy_ready", 64'(in_ready), 64'd0);
    end
    exp_cnt++;
    @(posedge clk); #1;
    chk("valid_fall", 64'(valid_out), 64'd0);
    chk("a_clear", 64'(matrix_a_out), 64'd0);
    chk("b_clear", 64'(matrix_b_out), 64'd0);
    chk("count", 64'(matrix_count), 64'(exp_cnt));
    n = 1;
    while (!in_ready && n < 50) begin
      in_a_row = rnd48();
      in_b_row = rnd48();
      @(posedge clk); #1;
      n++;
    end
    chk("drain_len", 64'(n), 64'(DC));
    in_valid = 0;
  endtask

  initial begin
    int   cyc_last;
    int   nb;
    int   beat;
    bit   acc;
    bit   prev_v;
    vec_t v0;

    tbl[0].a_in  = m3(1, 2, 3, 4, 5, 6, 7, 8, 9);
    tbl[0].b_in  = m3(9, 8, 7, 6, 5, 4, 3, 2, 1);
    tbl[0].a_exp = m3(1, 4, 7, 2, 5, 8, 3, 6, 9);
    tbl[0].b_exp = m3(9, 8, 7, 6, 5, 4, 3, 2, 1);
    tbl[0].gap   = 0;
    tbl[0].hold  = 0;
    tbl[1]       = tbl[0];
    tbl[1].gap   = 2;
    tbl[2].a_in  = m3(16'hFFFF, 1, 2, 3, 4, 5, 6, 7, 8);
    tbl[2].b_in  = m3(1, 2, 3, 4, 5, 6, 7, 8, 16'h8000);
    tbl[2].a_exp = m3(16'hFFFF, 3, 6, 1, 4, 7, 2, 5, 8);
    tbl[2].b_exp = m3(1, 2, 3, 4, 5, 6, 7, 8, 16'h8000);
    tbl[2].gap   = 1;
    tbl[2].hold  = 1;
    tbl[3].a_in  = m3(2, 3, 4, 5, 6, 7, 8, 9, 10);
    tbl[3].b_in  = m3(1, 2, 3, 4, 5, 6, 7, 8, 9);
    tbl[3].a_exp = m3(2, 5, 8, 3, 6, 9, 4, 7, 10);
    tbl[3].b_exp = m3(1, 2, 3, 4, 5, 6, 7, 8, 9);
    tbl[3].gap   = 0;
    tbl[3].hold  = 0;

    // reset state
    #2;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_a", 64'(matrix_a_out), 64'd0);
    chk("rst_b", 64'(matrix_b_out), 64'd0);
    chk("rst_count", 64'(matrix_count), 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // table-driven bursts
    for (int i = 0; i < 4; i++) begin
      load_beats(tbl[i]);
      check_burst(tbl[i]);
    end

    // reset in the middle of a burst
    v0 = tbl[0];
    load_beats(v0);
    @(posedge clk); #1;
    chk("mid_v1", 64'(valid_out), 64'd1);
    @(posedge clk); #1;
    chk("mid_v2", 64'(valid_out), 64'd1);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 64'(valid_out), 64'd0);
    chk("mid_rst_a", 64'(matrix_a_out), 64'd0);
    chk("mid_rst_b", 64'(matrix_b_out), 64'd0);
    chk("mid_rst_cnt", 64'(matrix_count), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("mid_ready_rel", 64'(in_ready), 64'd1);
    chk("mid_no_valid", 64'(valid_out), 64'd0);
    load_beats(tbl[3]);
    check_burst(tbl[3]);

    // back-to-back loads with in_valid held high
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    beat = 0;
    nb = 0;
    cyc_last = 0;
    prev_v = 0;
    for (int cyc = 0; cyc < 90; cyc++) begin
      in_valid = (beat < 4 * N);
      in_a_row = tbl[0].a_in[beat % N];
      in_b_row = tbl[0].b_in[beat % N];
      acc = in_ready && in_valid;
      @(posedge clk); #1;
      if (acc) beat++;
      if (valid_out && !prev_v) begin
        if (nb > 0)
          chk("b2b_spacing", 64'(cyc - cyc_last), 64'(2 * N + DC));
        chk("b2b_col0", 64'(matrix_a_out), 64'(tbl[0].a_exp[0]));
        cyc_last = cyc;
        nb++;
      end
      if (prev_v && !valid_out)
        chk("b2b_count", 64'(matrix_count), 64'(nb));
      prev_v = valid_out;
    end
    in_valid = 0;
    chk("b2b_bursts", 64'(nb), 64'd4);
    chk("b2b_final_cnt", 64'(matrix_count), 64'd4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
